store_write_buffer: RTL and testbench

- Posted-store buffer directly downstream of the MIPS core's data-memory port: consumes memwrite/dataadr/writedata.
- Queues stores in FIFO order and drains them to a slower data memory over a req/ack handshake, so the core does not wait on store latency.
- Provides load forwarding: a load to an address still in the buffer returns the youngest buffered data.
- Sits between top-level core and dmem; core stalls only when the buffer is full.

---
 rtl/swb_pkg.sv | 17 +
 rtl/swb_fwd_match.sv | 35 +++
 rtl/store_write_buffer.sv | 95 +++++++++
 tb/tb_store_write_buffer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/swb_pkg.sv
// Shared definitions for the posted-store write buffer: default sizes,
// the buffer entry layout and the pointer width.
package swb_pkg;

  localparam int SWB_DEPTH = 4;
  localparam int SWB_AW    = 32;
  localparam int SWB_DW    = 32;
  localparam int SWB_PW    = $clog2(SWB_DEPTH);

  // One buffered store: valid flag, word-aligned byte address, data.
  typedef struct packed {
    logic              valid;
    logic [SWB_AW-1:0] adr;
    logic [SWB_DW-1:0] data;
  } swb_entry_t;

endpackage

// File: rtl/swb_fwd_match.sv
// Load-forwarding lookup: scans the live entries oldest to youngest and
// returns the data of the youngest entry whose word address matches.
module swb_fwd_match
  import swb_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW
) (
  input  swb_entry_t               i_entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] i_rd_ptr,
  input  logic [$clog2(DEPTH):0]   i_count,
  input  logic [AW-1:0]            i_ld_adr,
  output logic                     o_ld_hit,
  output logic [DW-1:0]            o_ld_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Walk entries in age order; a later (younger) match overrides an earlier one.
  always_comb begin
    o_ld_hit  = 1'b0;
    o_ld_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < i_count) &&
          i_entries[i_rd_ptr + PW'(i)].valid &&
          (i_entries[i_rd_ptr + PW'(i)].adr[AW-1:2] == i_ld_adr[AW-1:2])) begin
        o_ld_hit  = 1'b1;
        o_ld_data = i_entries[i_rd_ptr + PW'(i)].data;
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer between the core data port and a slow data memory.
// Stores are queued in FIFO order and drained over mem_req/mem_ack; loads
// can be forwarded from the youngest matching buffered store.
module store_write_buffer
  import swb_pkg::*;
#(
  parameter int DEPTH = SWB_DEPTH,
  parameter int AW    = SWB_AW,
  parameter int DW    = SWB_DW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   memwrite,
  input  logic [AW-1:0]          dataadr,
  input  logic [DW-1:0]          writedata,
  input  logic [AW-1:0]          ld_adr,
  output logic                   ld_hit,
  output logic [DW-1:0]          ld_data,
  output logic                   stall,
  output logic                   mem_req,
  output logic [AW-1:0]          mem_adr,
  output logic [DW-1:0]          mem_wdata,
  input  logic                   mem_ack,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  swb_entry_t    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // A full buffer never accepts, even if the head pops on the same edge.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = memwrite & ~w_full;
  assign w_pop   = ~w_empty & mem_ack;

  // Entry storage and pointer/occupancy control; reset drops every pending store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      // When both happen the buffer is neither empty nor full, so the
      // write slot and the head slot are always distinct entries.
      if (w_push) begin
        r_mem[r_wr_ptr] <= '{valid: 1'b1, adr: dataadr, data: writedata};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_mem[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr              <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  assign stall     = memwrite & w_full;
  assign mem_req   = ~w_empty;
  assign mem_adr   = r_mem[r_rd_ptr].adr;
  assign mem_wdata = r_mem[r_rd_ptr].data;
  assign count     = r_count;
  assign empty     = w_empty;

  swb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd (
    .i_entries (r_mem),
    .i_rd_ptr  (r_rd_ptr),
    .i_count   (r_count),
    .i_ld_adr  (ld_adr),
    .o_ld_hit  (ld_hit),
    .o_ld_data (ld_data)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer: directed scenarios plus randomized
// traffic, checked against a queue-based reference model of the buffer.
module tb_store_write_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] ld_adr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [2:0]  count;
  logic        empty;

  store_write_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .dataadr   (dataadr),
    .writedata (writedata),
    .ld_adr    (ld_adr),
    .ld_hit    (ld_hit),
    .ld_data   (ld_data),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .count     (count),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];      // reference model contents, oldest at index 0
  ent_t dlog[$];   // what the memory side accepted, in order

  int n_vec;
  int n_err;
  int max_cnt;

  logic        s_stall, s_hit, s_req, s_empty, s_pushed;
  logic [2:0]  s_count;
  logic [31:0] s_data, s_adr, s_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs against the model
  // mid-cycle, then advance the model on the rising edge.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                      input logic ack, input logic [31:0] la);
    int          n;
    logic        ehit;
    logic [31:0] edata;
    memwrite  = mw;
    dataadr   = a;
    writedata = d;
    mem_ack   = ack;
    ld_adr    = la;
    @(negedge clk);
    s_stall = stall;  s_hit = ld_hit;    s_data = ld_data; s_req = mem_req;
    s_adr   = mem_adr; s_wdata = mem_wdata; s_count = count; s_empty = empty;
    n = q.size();
    chk("count", 64'(s_count), 64'(n));
    chk("empty", 64'(s_empty), 64'(n == 0));
    chk("mem_req", 64'(s_req), 64'(n != 0));
    chk("stall", 64'(s_stall), 64'(mw && (n == DEPTH)));
    if (n > 0) begin
      chk("mem_adr", 64'(s_adr), 64'(q[0].adr));
      chk("mem_wdata", 64'(s_wdata), 64'(q[0].data));
    end
    ehit  = 1'b0;
    edata = '0;
    foreach (q[i]) begin
      if (q[i].adr[31:2] == la[31:2]) begin
        ehit  = 1'b1;
        edata = q[i].data;
      end
    end
    chk("ld_hit", 64'(s_hit), 64'(ehit));
    chk("ld_data", 64'(s_data), 64'(edata));
    @(posedge clk);
    s_pushed = 1'b0;
    if (n > 0 && ack) begin
      q.delete(0);
      dlog.push_back('{s_adr, s_wdata});
    end
    if (mw && n < DEPTH) begin
      q.push_back('{a, d});
      s_pushed = 1'b1;
    end
    if (q.size() > max_cnt) max_cnt = q.size();
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFF0);
    chk("drained_empty", 64'(s_empty), 64'd1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; max_cnt = 0;
    reset = 1'b1; memwrite = 1'b0; dataadr = '0; writedata = '0;
    ld_adr = '0; mem_ack = 1'b0;
    #2;
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_hit", 64'(ld_hit), 64'd0);
    chk("rst_ldata", 64'(ld_data), 64'd0);
    chk("rst_madr", 64'(mem_adr), 64'd0);
    chk("rst_mwdata", 64'(mem_wdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic store with one-cycle latency to the memory side
    step(1'b1, 32'd84, 32'd7, 1'b1, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);
    chk("basic_req", 64'(s_req), 64'd1);
    chk("basic_adr", 64'(s_adr), 64'd84);
    chk("basic_wdata", 64'(s_wdata), 64'd7);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("basic_empty", 64'(s_empty), 64'd1);
    chk("basic_count", 64'(s_count), 64'd0);

    // Fill to full, stall, then no pass-through on the ack cycle
    for (int i = 0; i < 4; i++) step(1'b1, 32'(80 + 4 * i), 32'(i + 1), 1'b0, 32'd0);
    step(1'b1, 32'd96, 32'd5, 1'b0, 32'd0);
    chk("full_count", 64'(s_count), 64'd4);
    chk("full_stall", 64'(s_stall), 64'd1);
    step(1'b1, 32'd96, 32'd5, 1'b1, 32'd0);
    chk("ack_stall", 64'(s_stall), 64'd1);
    step(1'b1, 32'd96, 32'd5, 1'b0, 32'd0);
    chk("accept_nostall", 64'(s_stall), 64'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("refill_count", 64'(s_count), 64'd4);
    drain();

    // Forwarding: youngest of duplicate addresses wins, offset bits ignored
    step(1'b1, 32'd80, 32'd5, 1'b0, 32'd0);
    step(1'b1, 32'd84, 32'd7, 1'b0, 32'd0);
    step(1'b1, 32'd80, 32'd9, 1'b0, 32'd80);
    chk("fwd_not_same_cycle", 64'(s_data), 64'd5);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd80);
    chk("fwd80_hit", 64'(s_hit), 64'd1);
    chk("fwd80_data", 64'(s_data), 64'd9);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd82);
    chk("fwd82_data", 64'(s_data), 64'd9);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd88);
    chk("fwd88_hit", 64'(s_hit), 64'd0);
    chk("fwd88_data", 64'(s_data), 64'd0);
    drain();

    // Simultaneous enqueue and pop
    dlog.delete();
    step(1'b1, 32'd80, 32'd1, 1'b0, 32'd0);
    step(1'b1, 32'd84, 32'd2, 1'b0, 32'd0);
    step(1'b1, 32'd88, 32'd3, 1'b1, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("simul_count", 64'(s_count), 64'd2);
    drain();
    chk("simul_n", 64'(dlog.size()), 64'd3);
    if (dlog.size() == 3) begin
      chk("simul_o0", 64'(dlog[0].adr), 64'd80);
      chk("simul_o1", 64'(dlog[1].adr), 64'd84);
      chk("simul_o2", 64'(dlog[2].adr), 64'd88);
    end

    // Wrap-around with toggling ack
    dlog.delete();
    max_cnt = 0;
    begin
      int k;
      logic tg;
      k = 0; tg = 1'b0;
      for (int c = 0; c < 100 && k < 10; c++) begin
        step(1'b1, 32'(4 * k), 32'(k), tg, 32'(4 * k));
        if (s_pushed) k++;
        tg = ~tg;
      end
    end
    drain();
    chk("wrap_n", 64'(dlog.size()), 64'd10);
    for (int i = 0; i < 10 && i < dlog.size(); i++) begin
      chk("wrap_adr", 64'(dlog[i].adr), 64'(4 * i));
      chk("wrap_data", 64'(dlog[i].data), 64'(i));
    end
    chk("wrap_max", 64'(max_cnt <= DEPTH), 64'd1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 32'(100 + 4 * i), 32'(i), 1'b0, 32'd0);
    memwrite = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req", 64'(mem_req), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_madr", 64'(mem_adr), 64'd0);
    chk("arst_hit", 64'(ld_hit), 64'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 32'd84, 32'd7, 1'b1, 32'd0);
    step(1'b0, 32'd0, 32'd0, 1'b1, 32'd84);
    chk("post_rst_adr", 64'(s_adr), 64'd84);
    chk("post_rst_wdata", 64'(s_wdata), 64'd7);
    step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    chk("post_rst_empty", 64'(s_empty), 64'd1);

    // Randomized traffic over a small address set to exercise forwarding
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           32'($urandom_range(0, 7) * 4), $urandom,
           1'($urandom_range(0, 1)),
           32'($urandom_range(0, 8) * 4 + $urandom_range(0, 3)));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
